// File: rtl/split_ctrl_pkg.sv
// Shared types and helpers for the packet-level 1-in/2-out split scheduler.
package split_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} split_state_t;

   localparam int STAT_W = 16;

   function automatic int cred_w(int c);
      return $clog2(c + 1);
   endfunction

endpackage

// File: rtl/split_credit_ctr.sv
// Per-output credit counter: saturates at CREDITS and flags a sticky error on an
// over-return.
module split_credit_ctr
   import split_ctrl_pkg::*;
#(
   parameter int CREDITS = 4,
   localparam int CW = cred_w(CREDITS)
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          consume,
   input  logic          ret,
   output logic [CW-1:0] count,
   output logic          nonzero,
   output logic          err
);

   localparam logic [CW-1:0] FULL = CW'(CREDITS);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count <= FULL;
         err   <= 1'b0;
      end else begin
         // A return with every slot already free is a downstream protocol error.
         if (ret && count == FULL)
            err <= 1'b1;
         if (consume && !ret)
            count <= count - CW'(1);
         else if (ret && !consume && count != FULL)
            count <= count + CW'(1);
      end
   end

   assign nonzero = (count != '0);

endmodule

// File: rtl/split_route_ctrl.sv
// Packet scheduler steering each packet (token on Sel) to Out0 or Out1 under credit flow control.
// Build option: SPLIT_STATS_EN adds per-output completed-packet counters.
//
// state  | meaning
// IDLE   | waiting for a route token; no flits accepted
// ROUTE0 | forwarding flits of the current packet to Out0 until the tail
// ROUTE1 | forwarding flits of the current packet to Out1 until the tail
module split_route_ctrl
   import split_ctrl_pkg::*;
#(
   parameter int W       = 1,
   parameter int CREDITS = 4
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         Sel_data,
   input  logic         Sel_valid,
   output logic         Sel_ready,
   input  logic [W-1:0] In_data,
   input  logic         In_tail,
   input  logic         In_valid,
   output logic         In_ready,
   output logic [W-1:0] Out0_data,
   output logic         Out0_tail,
   output logic         Out0_valid,
   input  logic         Out0_ready,
   input  logic         Out0_credit,
   output logic [W-1:0] Out1_data,
   output logic         Out1_tail,
   output logic         Out1_valid,
   input  logic         Out1_ready,
   input  logic         Out1_credit,
   output logic         credit_err
`ifdef SPLIT_STATS_EN
   ,
   output logic [STAT_W-1:0] pkt_cnt0,
   output logic [STAT_W-1:0] pkt_cnt1
`endif
);

   localparam int CW = cred_w(CREDITS);

   split_state_t   state;
   logic [CW-1:0]  credit0, credit1;
   logic           cnz0, cnz1, err0, err1;
   logic           rdy0, rdy1, in_fire, sel_fire, load0, load1;
   logic           unused_credit;

   assign rdy0      = (state == ROUTE0) && cnz0 && (!Out0_valid || Out0_ready);
   assign rdy1      = (state == ROUTE1) && cnz1 && (!Out1_valid || Out1_ready);
   assign Sel_ready = !RESET && (state == IDLE);
   assign In_ready  = !RESET && (rdy0 || rdy1);
   assign sel_fire  = Sel_valid && Sel_ready;
   assign in_fire   = In_valid && In_ready;
   assign load0     = in_fire && (state == ROUTE0);
   assign load1     = in_fire && (state == ROUTE1);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         Out0_data  <= '0;
         Out0_tail  <= 1'b0;
         Out0_valid <= 1'b0;
         Out1_data  <= '0;
         Out1_tail  <= 1'b0;
         Out1_valid <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (sel_fire) state <= Sel_data ? ROUTE1 : ROUTE0;
            ROUTE0,
            ROUTE1:  if (in_fire && In_tail) state <= IDLE;
            default: state <= IDLE;
         endcase
         // Load wins over unload so the register can drain and refill in one cycle.
         if (load0) begin
            Out0_data  <= In_data;
            Out0_tail  <= In_tail;
            Out0_valid <= 1'b1;
         end else if (Out0_valid && Out0_ready) begin
            Out0_valid <= 1'b0;
         end
         if (load1) begin
            Out1_data  <= In_data;
            Out1_tail  <= In_tail;
            Out1_valid <= 1'b1;
         end else if (Out1_valid && Out1_ready) begin
            Out1_valid <= 1'b0;
         end
      end
   end

   split_credit_ctr #(.CREDITS(CREDITS)) u_cred0 (
      .CLK(CLK), .RESET(RESET), .consume(load0), .ret(Out0_credit),
      .count(credit0), .nonzero(cnz0), .err(err0)
   );

   split_credit_ctr #(.CREDITS(CREDITS)) u_cred1 (
      .CLK(CLK), .RESET(RESET), .consume(load1), .ret(Out1_credit),
      .count(credit1), .nonzero(cnz1), .err(err1)
   );

   assign credit_err    = err0 || err1;
   assign unused_credit = ^{credit0, credit1};

`ifdef SPLIT_STATS_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (Out0_valid && Out0_ready && Out0_tail)
            pkt_cnt0 <= pkt_cnt0 + STAT_W'(1);
         if (Out1_valid && Out1_ready && Out1_tail)
            pkt_cnt1 <= pkt_cnt1 + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_split_route_ctrl.sv
// Bench for split_route_ctrl: directed scenarios plus random traffic against a packet-level model.
module tb_split_route_ctrl;

   localparam int W       = 8;
   localparam int CREDITS = 4;

   logic         CLK = 1'b0;
   logic         RESET = 1'b1;
   logic         Sel_data = 1'b0, Sel_valid = 1'b0;
   logic         Sel_ready;
   logic [W-1:0] In_data = '0;
   logic         In_tail = 1'b0, In_valid = 1'b0;
   logic         In_ready;
   logic [W-1:0] Out0_data, Out1_data;
   logic         Out0_tail, Out0_valid, Out1_tail, Out1_valid;
   logic         Out0_ready = 1'b0, Out1_ready = 1'b0;
   logic         Out0_credit = 1'b0, Out1_credit = 1'b0;
   logic         credit_err;
`ifdef SPLIT_STATS_EN
   logic [15:0]  pkt_cnt0, pkt_cnt1;
`endif

   split_route_ctrl #(.W(W), .CREDITS(CREDITS)) dut (
      .CLK(CLK), .RESET(RESET),
      .Sel_data(Sel_data), .Sel_valid(Sel_valid), .Sel_ready(Sel_ready),
      .In_data(In_data), .In_tail(In_tail), .In_valid(In_valid), .In_ready(In_ready),
      .Out0_data(Out0_data), .Out0_tail(Out0_tail), .Out0_valid(Out0_valid),
      .Out0_ready(Out0_ready), .Out0_credit(Out0_credit),
      .Out1_data(Out1_data), .Out1_tail(Out1_tail), .Out1_valid(Out1_valid),
      .Out1_ready(Out1_ready), .Out1_credit(Out1_credit),
      .credit_err(credit_err)
`ifdef SPLIT_STATS_EN
      , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: route is -1 when no packet is open, else the output index.
   int         route;
   int         cred [2];
   bit         ov   [2];
   bit [W-1:0] od   [2];
   bit         ot   [2];
   bit         m_err;
   int         pkt  [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      route = -1;
      m_err = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cred[k] = CREDITS;
         ov[k]   = 1'b0;
         od[k]   = '0;
         ot[k]   = 1'b0;
         pkt[k]  = 0;
      end
   endtask

   // One clock cycle: drive, compare against the model, advance the model.
   task automatic step(input bit sv, input bit sd, input bit iv, input logic [W-1:0] id,
                       input bit it, input bit r0, input bit r1, input bit c0, input bit c1,
                       output bit fired);
      bit exp_sr, exp_ir, sel_fire, in_fire;
      bit rr [2];
      bit cc [2];
      int nxt;
      @(negedge CLK);
      Sel_valid = sv; Sel_data = sd; In_valid = iv; In_data = id; In_tail = it;
      Out0_ready = r0; Out1_ready = r1; Out0_credit = c0; Out1_credit = c1;
      rr[0] = r0; rr[1] = r1; cc[0] = c0; cc[1] = c1;
      #1;
      exp_sr = (route < 0);
      exp_ir = 1'b0;
      if (route >= 0)
         exp_ir = (cred[route] > 0) && (!ov[route] || rr[route]);
      chk("sel_ready", 32'(Sel_ready), 32'(exp_sr));
      chk("in_ready", 32'(In_ready), 32'(exp_ir));
      chk("out0_valid", 32'(Out0_valid), 32'(ov[0]));
      chk("out1_valid", 32'(Out1_valid), 32'(ov[1]));
      if (ov[0]) begin
         chk("out0_data", 32'(Out0_data), 32'(od[0]));
         chk("out0_tail", 32'(Out0_tail), 32'(ot[0]));
      end
      if (ov[1]) begin
         chk("out1_data", 32'(Out1_data), 32'(od[1]));
         chk("out1_tail", 32'(Out1_tail), 32'(ot[1]));
      end
      chk("credit_err", 32'(credit_err), 32'(m_err));
      chk("credit0", 32'(dut.credit0), 32'(cred[0]));
      chk("credit1", 32'(dut.credit1), 32'(cred[1]));
`ifdef SPLIT_STATS_EN
      chk("pkt_cnt0", 32'(pkt_cnt0), 32'(pkt[0]));
      chk("pkt_cnt1", 32'(pkt_cnt1), 32'(pkt[1]));
`endif
      sel_fire = sv && exp_sr;
      in_fire  = iv && exp_ir;
      for (int k = 0; k < 2; k++) begin
         bit load, unload;
         load   = in_fire && (route == k);
         unload = ov[k] && rr[k];
         if (unload && ot[k]) pkt[k] = (pkt[k] + 1) % 65536;
         if (load) begin
            ov[k] = 1'b1; od[k] = id; ot[k] = it;
         end else if (unload) begin
            ov[k] = 1'b0;
         end
         if (cc[k] && cred[k] == CREDITS) m_err = 1'b1;
         nxt = cred[k] - (load ? 1 : 0) + (cc[k] ? 1 : 0);
         cred[k] = (nxt > CREDITS) ? CREDITS : nxt;
      end
      if (route < 0) begin
         if (sel_fire) route = sd ? 1 : 0;
      end else if (in_fire && it) begin
         route = -1;
      end
      fired = in_fire;
      @(posedge CLK);
   endtask

   task automatic idle(input bit r0, input bit r1);
      bit f;
      step(0, 0, 0, '0, 0, r0, r1, 0, 0, f);
   endtask

   task automatic refill();
      bit f;
      for (int i = 0; i < 2 * CREDITS; i++)
         step(0, 0, 0, '0, 0, 1, 1, cred[0] < CREDITS, cred[1] < CREDITS, f);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #2 RESET = 1'b1;
      Sel_valid = 0; In_valid = 0; Out0_credit = 0; Out1_credit = 0;
      #1;
      chk("rst_sel_ready", 32'(Sel_ready), 32'd0);
      chk("rst_in_ready", 32'(In_ready), 32'd0);
      chk("rst_out0_valid", 32'(Out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(Out1_valid), 32'd0);
      chk("rst_credit0", 32'(dut.credit0), CREDITS);
      chk("rst_credit_err", 32'(credit_err), 32'd0);
`ifdef SPLIT_STATS_EN
      chk("rst_pkt_cnt0", 32'(pkt_cnt0), 32'd0);
`endif
      model_reset();
      @(negedge CLK);
      #2 RESET = 1'b0;
   endtask

   initial begin
      bit f;
      int acc, idx, guard;
      model_reset();
      #12 RESET = 1'b0;

      // 1: reset state and first cycle after release
      idle(0, 0);
      chk("t1_sel_ready", 32'(Sel_ready), 32'd1);

      // 2: three-flit packet to Out1
      step(1, 1, 0, '0, 0, 1, 1, 0, 0, f);
      step(0, 0, 1, 8'hA1, 0, 1, 1, 0, 0, f);
      step(0, 0, 1, 8'hB2, 0, 1, 1, 0, 0, f);
      step(0, 0, 1, 8'hC3, 1, 1, 1, 0, 0, f);
      idle(1, 1);
      chk("t2_sel_ready", 32'(Sel_ready), 32'd1);
      chk("t2_credit1", 32'(dut.credit1), 32'd1);
      refill();

      // 3: six-flit packet to Out0 with credits withheld
      step(1, 0, 0, '0, 0, 1, 1, 0, 0, f);
      acc = 0; idx = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, W'(idx), idx == 5, 1, 1, 0, 0, f);
         if (f) begin acc++; idx++; end
      end
      chk("t3_accepted", 32'(acc), 32'd4);
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, W'(idx), idx == 5, 1, 1, i == 0, 0, f);
         if (f) begin acc++; idx++; end
      end
      chk("t3_one_more", 32'(acc), 32'd1);
      guard = 0;
      while (idx <= 5 && guard < 20) begin
         step(0, 0, 1, W'(idx), idx == 5, 1, 1, cred[0] < CREDITS, 0, f);
         if (f) idx++;
         guard++;
      end
      chk("t3_done", 32'(idx), 32'd6);
      refill();

      // 4: backpressure on Out0 then same-cycle unload/reload
      step(1, 0, 0, '0, 0, 0, 0, 0, 0, f);
      step(0, 0, 1, 8'h55, 0, 0, 0, 0, 0, f);
      step(0, 0, 1, 8'h66, 0, 0, 0, 0, 0, f);
      chk("t4_stalled", 32'(f), 32'd0);
      step(0, 0, 1, 8'h66, 0, 0, 0, 0, 0, f);
      chk("t4_held_data", 32'(Out0_data), 32'h55);
      step(0, 0, 1, 8'h66, 0, 1, 0, 0, 0, f);
      chk("t4_reload", 32'(f), 32'd1);
      step(0, 0, 1, 8'h77, 1, 1, 0, 0, 0, f);
      idle(1, 1);
      refill();

      // 5: over-return on Out1 and simultaneous consume/return
      step(0, 0, 0, '0, 0, 1, 1, 0, 1, f);
      idle(1, 1);
      chk("t5_err", 32'(credit_err), 32'd1);
      step(1, 1, 0, '0, 0, 1, 1, 0, 0, f);
      step(0, 0, 1, 8'h11, 0, 1, 1, 0, 0, f);
      step(0, 0, 1, 8'h22, 1, 1, 1, 0, 1, f);
      idle(1, 1);
      chk("t5_cred_hold", 32'(dut.credit1), 32'(CREDITS - 1));

      // 6: reset mid-packet
      step(1, 0, 0, '0, 0, 1, 1, 0, 0, f);
      step(0, 0, 1, 8'h01, 0, 1, 1, 0, 0, f);
      step(0, 0, 1, 8'h02, 0, 0, 1, 0, 0, f);
      do_reset();
      idle(0, 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              cred[0] < CREDITS && $urandom_range(0, 2) == 0,
              cred[1] < CREDITS && $urandom_range(0, 2) == 0, f);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
